// File: rtl/worker_result_arbiter_pkg.sv
// Shared definitions for the worker-result arbiter: default sizes and FSM state encoding.
package worker_result_arbiter_pkg;

  localparam int DEFAULT_WORKER_RESULT_WIDTH = 8;
  localparam int DEFAULT_NUM_WORKERS         = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_GRANT = 2'b01,
    S_SEND  = 2'b10
  } state_e;

endpackage

// File: rtl/worker_result_arbiter_rr_priority_encoder.sv
// Round-robin priority encoder: picks the first set request bit at or after ptr, wrapping.
// Purely combinational so the packet-request path can reuse it.
module rr_priority_encoder #(
  parameter int NUM_WORKERS = 4,
  parameter int GRANT_WIDTH = $clog2(NUM_WORKERS)
) (
  input  logic [NUM_WORKERS-1:0] req,
  input  logic [GRANT_WIDTH-1:0] ptr,
  output logic [GRANT_WIDTH-1:0] grant,
  output logic                   any_req
);

  logic [2*NUM_WORKERS-1:0] doubled;
  logic [NUM_WORKERS-1:0]   rotated;
  logic [GRANT_WIDTH-1:0]   offset;

  // Rotate so ptr lands at bit 0, find the lowest set bit, then rotate the index back.
  // NOTE: every variable written in a combinational block gets a default first, so no path leaves it holding a stale value (latch).
  always_comb begin
    doubled = {req, req} >> ptr;
    rotated = doubled[NUM_WORKERS-1:0];
    offset  = '0;
    for (int i = NUM_WORKERS - 1; i >= 0; i--) begin
      if (rotated[i]) offset = GRANT_WIDTH'(i);
    end
    grant   = ptr + offset;
    any_req = |req;
  end

endmodule

// File: rtl/worker_result_arbiter.sv
// Merges NUM_WORKERS worker-result streams into one registered stream toward the dispatcher,
// round-robin arbitrated, one result in flight at a time.
module worker_result_arbiter
  import worker_result_arbiter_pkg::*;
#(
  parameter int NUM_WORKERS         = DEFAULT_NUM_WORKERS,
  parameter int WORKER_RESULT_WIDTH = DEFAULT_WORKER_RESULT_WIDTH,
  parameter int GRANT_WIDTH         = $clog2(NUM_WORKERS)
) (
  input  logic                                       CLK,
  input  logic                                       RST,
  input  logic [NUM_WORKERS-1:0]                     RECEIVE_WR_VALID,
  input  logic [NUM_WORKERS*WORKER_RESULT_WIDTH-1:0] RECEIVE_WR_DATA,
  output logic [NUM_WORKERS-1:0]                     RECEIVE_WR_READY,
  output logic                                       SEND_WR_VALID,
  output logic [WORKER_RESULT_WIDTH-1:0]             SEND_WR_DATA,
  input  logic                                       SEND_WR_READY,
  output logic [GRANT_WIDTH-1:0]                     LAST_GRANT
);

  state_e                         state_q, state_d;
  logic [GRANT_WIDTH-1:0]         ptr_q;
  logic [GRANT_WIDTH-1:0]         grant_q;
  logic [GRANT_WIDTH-1:0]         last_grant_q;
  logic [WORKER_RESULT_WIDTH-1:0] data_q;

  logic [GRANT_WIDTH-1:0]         enc_grant;
  logic                           enc_any;
  logic [WORKER_RESULT_WIDTH-1:0] slot_data;
  logic                           accept;

  rr_priority_encoder #(
    .NUM_WORKERS (NUM_WORKERS),
    .GRANT_WIDTH (GRANT_WIDTH)
  ) u_rr_enc (
    .req     (RECEIVE_WR_VALID),
    .ptr     (ptr_q),
    .grant   (enc_grant),
    .any_req (enc_any)
  );

  always_comb begin
    slot_data = '0;
    for (int i = 0; i < NUM_WORKERS; i++) begin
      if (grant_q == GRANT_WIDTH'(i))
        slot_data = RECEIVE_WR_DATA[i*WORKER_RESULT_WIDTH +: WORKER_RESULT_WIDTH];
    end
  end

  // READY[grant_q] is high in S_GRANT, so VALID of that slot alone decides the transfer.
  assign accept = (state_q == S_GRANT) && RECEIVE_WR_VALID[grant_q];

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      grant_q      <= '0;
      last_grant_q <= '0;
      data_q       <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && enc_any) grant_q <= enc_grant;
      if (accept) begin
        data_q       <= slot_data;
        last_grant_q <= grant_q;
        ptr_q        <= grant_q + GRANT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (enc_any) state_d = S_GRANT;
      S_GRANT: state_d = RECEIVE_WR_VALID[grant_q] ? S_SEND : S_IDLE;
      S_SEND:  if (SEND_WR_READY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode registered state only, so they are glitch-free and registered in timing.
  always_comb begin
    RECEIVE_WR_READY = '0;
    if (state_q == S_GRANT) RECEIVE_WR_READY[grant_q] = 1'b1;
    SEND_WR_VALID = (state_q == S_SEND);
    SEND_WR_DATA  = data_q;
    LAST_GRANT    = last_grant_q;
  end

endmodule

// File: tb/tb_worker_result_arbiter.sv
// Directed bench for worker_result_arbiter: per-worker send queues, expected-result scoreboard.
module tb_worker_result_arbiter;
  import worker_result_arbiter_pkg::*;

  localparam int NW = 4;
  localparam int W  = 8;
  localparam int GW = 2;

  typedef struct {
    logic [GW-1:0] slot;
    logic [W-1:0]  data;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [NW-1:0]   rx_valid;
  logic [NW*W-1:0] rx_data;
  logic [NW-1:0]   rx_ready;
  logic            tx_valid;
  logic [W-1:0]    tx_data;
  logic            tx_ready;
  logic [GW-1:0]   last_grant;

  worker_result_arbiter #(
    .NUM_WORKERS         (NW),
    .WORKER_RESULT_WIDTH (W),
    .GRANT_WIDTH         (GW)
  ) dut (
    .CLK              (clk),
    .RST              (rst),
    .RECEIVE_WR_VALID (rx_valid),
    .RECEIVE_WR_DATA  (rx_data),
    .RECEIVE_WR_READY (rx_ready),
    .SEND_WR_VALID    (tx_valid),
    .SEND_WR_DATA     (tx_data),
    .SEND_WR_READY    (tx_ready),
    .LAST_GRANT       (last_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] worker_q [NW][$];
  logic [NW-1:0] mute;
  exp_t exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_workers();
    for (int i = 0; i < NW; i++) begin
      rx_valid[i] = (worker_q[i].size() > 0) && !mute[i];
      rx_data[i*W +: W] = (worker_q[i].size() > 0) ? worker_q[i][0] : '0;
    end
  endtask

  // One clock: sample handshakes at negedge, score the dispatcher side, advance workers after the edge.
  task automatic cycle();
    logic [NW-1:0] rdy, vld;
    logic sv, sr;
    exp_t e;
    @(negedge clk);
    rdy = rx_ready;
    vld = rx_valid;
    sv  = tx_valid;
    sr  = tx_ready;
    check("ready_onehot0", {31'd0, $onehot0(rdy)}, 32'd1);
    if (sv && sr) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {24'd0, tx_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", {24'd0, tx_data}, {24'd0, e.data});
        check("sb_slot", {30'd0, last_grant}, {30'd0, e.slot});
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NW; i++) begin
      if (rdy[i] && vld[i] && worker_q[i].size() > 0) void'(worker_q[i].pop_front());
    end
    drive_workers();
  endtask

  task automatic drain(input int budget, output int used);
    used = 0;
    while (exp_q.size() > 0 && used < budget) begin
      cycle();
      used++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic push(input int slot, input logic [W-1:0] d, input bit expect_it);
    exp_t e;
    worker_q[slot].push_back(d);
    if (expect_it) begin
      e.slot = GW'(slot);
      e.data = d;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    int used;
    rst = 1'b1;
    tx_ready = 1'b0;
    mute = '0;
    rx_valid = '0;
    rx_data = '0;
    @(posedge clk);
    #1;
    cycle();
    check("rst_ready", rx_ready, 0);
    check("rst_svalid", tx_valid, 0);
    check("rst_sdata", tx_data, 0);
    check("rst_lgrant", last_grant, 0);
    rst = 1'b0;
    cycle();

    // Single request on slot 2.
    tx_ready = 1'b1;
    push(2, 8'hA5, 1'b1);
    drive_workers();
    cycle();
    check("t1_ready", rx_ready, 4'b0100);
    check("t1_svalid_early", tx_valid, 0);
    cycle();
    check("t1_ready_drop", rx_ready, 0);
    check("t1_svalid", tx_valid, 1);
    check("t1_sdata", tx_data, 8'hA5);
    check("t1_lgrant", last_grant, 2);
    cycle();
    check("t1_svalid_done", tx_valid, 0);
    check("t1_sb_empty", exp_q.size(), 0);

    // Wrap-around: ptr=3, slots 3 and 0 request together.
    push(3, 8'h33, 1'b1);
    push(0, 8'h30, 1'b1);
    drive_workers();
    drain(20, used);
    check("wrap_cycles", used, 6);

    // ptr must now be 1: slots 0 and 2 request, 2 wins first.
    push(0, 8'h40, 1'b0);
    push(2, 8'h42, 1'b1);
    exp_q.push_back('{slot: 2'd0, data: 8'h40});
    drive_workers();
    drain(20, used);

    // Backpressure: slot 1 result held for 10 cycles while slot 2 waits.
    tx_ready = 1'b0;
    push(1, 8'h51, 1'b1);
    push(2, 8'h52, 1'b1);
    drive_workers();
    cycle();
    check("bp_ready", rx_ready, 4'b0010);
    cycle();
    for (int k = 0; k < 10; k++) begin
      check("bp_svalid", tx_valid, 1);
      check("bp_sdata", tx_data, 8'h51);
      check("bp_ready_zero", rx_ready, 0);
      cycle();
    end
    tx_ready = 1'b1;
    drain(20, used);

    // Protocol violation: slot 1 drops VALID while granted; ptr stays 3.
    push(1, 8'h61, 1'b1);
    drive_workers();
    cycle();
    check("pv_ready", rx_ready, 4'b0010);
    mute[1] = 1'b1;
    drive_workers();
    cycle();
    check("pv_svalid", tx_valid, 0);
    check("pv_ready_drop", rx_ready, 0);
    check("pv_lgrant", last_grant, 2);
    cycle();
    check("pv_idle", rx_ready, 0);
    mute[1] = 1'b0;
    push(2, 8'h62, 1'b1);
    drive_workers();
    drain(20, used);

    // Reset while a result is held: it must never reach the dispatcher.
    tx_ready = 1'b0;
    push(0, 8'h77, 1'b0);
    drive_workers();
    cycle();
    cycle();
    check("rs_svalid_pre", tx_valid, 1);
    check("rs_sdata_pre", tx_data, 8'h77);
    rst = 1'b1;
    cycle();
    check("rs_ready", rx_ready, 0);
    check("rs_svalid", tx_valid, 0);
    check("rs_sdata", tx_data, 0);
    check("rs_lgrant", last_grant, 0);
    rst = 1'b0;
    tx_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("rs_no_present", tx_valid, 0);
    end

    // Fairness from ptr=0 with all workers requesting continuously.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NW; i++) push(i, W'(8'h10 + 8'h10 * r + i), 1'b1);
    end
    drive_workers();
    drain(60, used);
    check("fair_cycles", used, 24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
